alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//   Command buffer and result register directly upstream/downstream of the combinational 32-bit ALU.
//   Accepts {op, A, B, chain} commands over valid/ready, queues them in a FIFO and drives the head entry onto the ALU operand/op ports.
//   Registers the ALU result C and presents it over a valid/ready output.
//   Optional chaining substitutes the previous result for A, allowing accumulation sequences without software round-trips.
// PARAMETERS
//   DEPTH  4   command FIFO entries; power of two, >= 2
//   CW     3   width of count output; must equal $clog2(DEPTH+1)
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   command present
//   in_ready   out  1   FIFO can accept (= !full)
//   in_op      in   3   ALUOp: 0 add, 1 sub, 2 and, 3 or, 4 srl, 5-7 sra
//   in_a       in   32  operand A (ignored when in_chain=1)
//   in_b       in   32  operand B / shift amount
//   in_chain   in   1   1: use last_result as A
//   alu_a      out  32  to ALU A
//   alu_b      out  32  to ALU B
//   alu_op     out  3   to ALU ALUOp
//   alu_c      in   32  from ALU C (combinational)
//   out_valid  out  1   result held
//   out_ready  in   1   consumer takes result
//   out_c      out  32  registered result
//   out_op     out  3   op that produced out_c
//   count      out  CW  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset (async, any cycle): FIFO emptied (count=0, pointers 0), out_valid=0, out_c=0, out_op=0, last_result=0; in-flight commands discarded.
//   Push: in_valid && in_ready at a clk edge writes the tail entry; pointers wrap modulo DEPTH.
//   in_ready = (count != DEPTH); no push into a full FIFO even if a pop occurs the same cycle.
//   ALU drive (combinational from head): non-empty -> alu_op=head.op, alu_b=head.b, alu_a = head.chain ? last_result : head.a.
//   Empty -> alu_a=alu_b=0, alu_op=0.
//   Issue condition: count!=0 && (!out_valid || out_ready).
//   On issue edge: out_c<=alu_c, out_op<=head.op, last_result<=alu_c, out_valid<=1, head popped.
//   out_valid clears only on out_ready && no issue in the same cycle; a consumer handshake plus issue in the same cycle gives back-to-back results.
//   Stall: out_valid && !out_ready -> out_c/out_op held stable, no pop, FIFO keeps filling until full.
//   last_result persists after the result is consumed; it changes only on issue or reset.
//   Chain with no prior issue since reset uses last_result=0.
//   Simultaneous push and issue: count unchanged; a push into an empty FIFO is not issued in the same cycle (no bypass).
//   Latency: push at edge N -> issue at edge N+1 -> out_valid high after edge N+1 (throughput 1/cycle when out_ready=1).
//   Ops are forwarded unmodified; values 6 and 7 behave as arithmetic right shift at the ALU.
//   Arithmetic is 32-bit wrap, no flags.
//   count: +1 on push only, -1 on issue only, unchanged on both.
// TESTING
//   Single cmd: push op0 A=5 B=7 with out_ready=1 -> out_valid one edge after push, out_c=12, out_op=0, count returns to 0.
//   Chain: push {op0,3,4,0}, {op1,x,2,1}, {op5,x,1,1} -> out_c sequence 7, 5, 2; with A=0x80000000 start and op5 B=4, chained result=0xF8000000.
//   Backpressure: out_ready=0, push 5 cmds with DEPTH=4 -> first result held; after 4 further pushes count=4, in_ready=0; the 6th push is refused.
//   Drain: release out_ready -> all results arrive in order, one per cycle, with no duplicates or drops.
//   Wrap: stream 10 cmds {op2, A=i, B=0xF} with random out_ready -> results i&0xF in order; pointers wrap cleanly.
//   Mid-op reset: assert reset with count=3 and out_valid=1 -> in the same cycle out_valid=0 and count=0; the next chain cmd {op0,x,9,1} -> out_c=9.
//   Shift edge: push op4 A=0xFFFFFFFF B=31 -> out_c=1; push op6 A=0x80000000 B=31 -> out_c=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Command FIFO feeding a combinational 32-bit ALU, with a registered result stage on a valid/ready output.
// Chained commands take the most recently issued result as operand A.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [31:0]   in_a,
   input  logic [31:0]   in_b,
   input  logic          in_chain,
   output logic [31:0]   alu_a,
   output logic [31:0]   alu_b,
   output logic [2:0]    alu_op,
   input  logic [31:0]   alu_c,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_c,
   output logic [2:0]    out_op,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        chain;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   cmd_t          in_cmd;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   last_result;
   logic          empty;
   logic          full;
   logic          push;
   logic          issue;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && !full;
   // A held result blocks issue until the consumer takes it; the same edge may then refill the stage.
   assign issue    = !empty && (!out_valid || out_ready);
   assign head     = mem[rd_ptr];
   assign in_cmd   = '{op: in_op, a: in_a, b: in_b, chain: in_chain};

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      if (!empty) begin
         alu_op = head.op;
         alu_b  = head.b;
         alu_a  = head.chain ? last_result : head.a;
      end
   end

   // NOTE: the entry storage has no reset; an entry is only ever read while count says it is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_cmd;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (issue)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, issue})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_c       <= '0;
         out_op      <= '0;
         last_result <= '0;
      end else if (issue) begin
         out_valid   <= 1'b1;
         out_c       <= alu_c;
         out_op      <= head.op;
         last_result <= alu_c;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: a transaction-level queue model checked every cycle, plus directed
// scenarios whose consumed results are compared against hand-computed literals.
module tb_alu_issue_queue;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = '0;
   logic [31:0]   in_a = '0;
   logic [31:0]   in_b = '0;
   logic          in_chain = 1'b0;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [2:0]    alu_op;
   logic [31:0]   alu_c;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_c;
   logic [2:0]    out_op;
   logic [CW-1:0] count;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;

   alu_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .in_chain(in_chain), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_op(out_op),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a >> b[4:0];
         default: return $signed(a) >>> b[4:0];
      endcase
   endfunction

   // The external ALU the block sits in front of.
   assign alu_c = alu_ref(alu_op, alu_a, alu_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model: a queue of pending commands and the result slot.
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        chain;
   } mcmd_t;

   mcmd_t       mq[$];
   mcmd_t       m_head;
   mcmd_t       m_new;
   logic        m_valid = 1'b0;
   logic [31:0] m_c = '0;
   logic [2:0]  m_op = '0;
   logic [31:0] m_last = '0;
   bit          m_iss;
   bit          m_psh;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_valid = 1'b0;
         m_c     = '0;
         m_op    = '0;
         m_last  = '0;
      end else begin
         m_iss = (mq.size() != 0) && (!m_valid || out_ready);
         m_psh = in_valid && (mq.size() < DEPTH);
         if (m_iss) begin
            m_head  = mq.pop_front();
            m_c     = alu_ref(m_head.op, m_head.chain ? m_last : m_head.a, m_head.b);
            m_op    = m_head.op;
            m_last  = m_c;
            m_valid = 1'b1;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (m_psh) begin
            m_new = '{op: in_op, a: in_a, b: in_b, chain: in_chain};
            mq.push_back(m_new);
         end
      end
   end

   always @(posedge clk) cyc_n++;

   // Consumed results, with the cycle in which each was taken.
   logic [31:0] got_c[$];
   int          got_t[$];

   always @(negedge clk) begin
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("out_c", out_c, m_c);
         check("out_op", out_op, m_op);
      end
      check("count", count, mq.size());
      check("in_ready", in_ready, mq.size() != DEPTH);
      if (mq.size() != 0) begin
         check("alu_a", alu_a, mq[0].chain ? m_last : mq[0].a);
         check("alu_b", alu_b, mq[0].b);
         check("alu_op", alu_op, mq[0].op);
      end else begin
         check("alu_a_idle", alu_a, 0);
         check("alu_op_idle", alu_op, 0);
      end
      if (!reset && out_valid && out_ready) begin
         got_c.push_back(out_c);
         got_t.push_back(cyc_n);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic ch);
      int n = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_chain = ch;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("push_accept", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_results(input string name, input int n);
      int k = 0;
      while (got_c.size() < n && k < 200) begin
         step();
         k++;
      end
      check(name, got_c.size(), n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step();
      step();
      reset = 1'b0;
      step();
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_c", out_c, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_alu_a", alu_a, 0);

      // Single command: result valid one edge after the push.
      out_ready = 1'b1;
      got_c.delete(); got_t.delete();
      push_cmd(3'd0, 32'd5, 32'd7, 1'b0);
      check("single_count_after_push", count, 1);
      check("single_valid_after_push", out_valid, 0);
      step();
      check("single_valid", out_valid, 1);
      check("single_c", out_c, 12);
      check("single_op", out_op, 0);
      check("single_count", count, 0);
      wait_results("single_n", 1);
      check("single_got", got_c[0], 12);
      step();

      // Chaining accumulates through last_result.
      got_c.delete(); got_t.delete();
      push_cmd(3'd0, 32'd3, 32'd4, 1'b0);
      push_cmd(3'd1, 32'hDEAD_BEEF, 32'd2, 1'b1);
      push_cmd(3'd5, 32'h1234_5678, 32'd1, 1'b1);
      push_cmd(3'd0, 32'h8000_0000, 32'd0, 1'b0);
      push_cmd(3'd5, 32'h0BAD_F00D, 32'd4, 1'b1);
      wait_results("chain_n", 5);
      check("chain_0", got_c[0], 32'd7);
      check("chain_1", got_c[1], 32'd5);
      check("chain_2", got_c[2], 32'd2);
      check("chain_3", got_c[3], 32'h8000_0000);
      check("chain_4", got_c[4], 32'hF800_0000);
      step();

      // Backpressure: one result held, FIFO fills to DEPTH, further pushes refused.
      out_ready = 1'b0;
      step();
      got_c.delete(); got_t.delete();
      for (int i = 0; i < 5; i++) push_cmd(3'd0, i, 32'd100, 1'b0);
      check("bp_count", count, 4);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_c", out_c, 100);
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_a     = 32'd7;
      in_b     = 32'd7;
      in_chain = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_refused_count", count, 4);
         check("bp_held_c", out_c, 100);
      end
      in_valid = 1'b0;

      // Drain: results in order, one per cycle.
      out_ready = 1'b1;
      wait_results("drain_n", 5);
      for (int i = 0; i < 5; i++) check("drain_val", got_c[i], 100 + i);
      for (int i = 1; i < 5; i++) check("drain_gap", got_t[i] - got_t[i-1], 1);
      step();
      step();
      check("drain_count", count, 0);
      check("drain_valid", out_valid, 0);

      // Wrap: ten commands with random consumer readiness.
      got_c.delete(); got_t.delete();
      for (int i = 0; i < 10; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!in_ready) out_ready = 1'b1;
         push_cmd(3'd2, i * 32'h1111_1111, 32'h0000_000F, 1'b0);
      end
      out_ready = 1'b1;
      wait_results("wrap_n", 10);
      for (int i = 0; i < 10; i++) check("wrap_val", got_c[i], i);
      step();

      // Mid-operation reset clears everything immediately.
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 4; i++) push_cmd(3'd0, i, 32'd1, 1'b0);
      check("mr_count_pre", count, 3);
      check("mr_valid_pre", out_valid, 1);
      reset = 1'b1;
      #1;
      check("mr_valid", out_valid, 0);
      check("mr_count", count, 0);
      check("mr_in_ready", in_ready, 1);
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      got_c.delete(); got_t.delete();
      push_cmd(3'd0, 32'hDEAD_0000, 32'd9, 1'b1);
      wait_results("mr_n", 1);
      check("mr_chain", got_c[0], 9);
      step();

      // Shift edges and wrap-around arithmetic.
      got_c.delete(); got_t.delete();
      push_cmd(3'd4, 32'hFFFF_FFFF, 32'd31, 1'b0);
      push_cmd(3'd6, 32'h8000_0000, 32'd31, 1'b0);
      push_cmd(3'd7, 32'h7FFF_FFFF, 32'd1, 1'b0);
      push_cmd(3'd1, 32'd0, 32'd1, 1'b0);
      push_cmd(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
      push_cmd(3'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0);
      wait_results("shift_n", 6);
      check("srl31", got_c[0], 32'h0000_0001);
      check("sra31_op6", got_c[1], 32'hFFFF_FFFF);
      check("sra1_op7", got_c[2], 32'h3FFF_FFFF);
      check("sub_wrap", got_c[3], 32'hFFFF_FFFF);
      check("add_wrap", got_c[4], 32'h0000_0001);
      check("or", got_c[5], 32'h0000_00FF);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
